// File: rtl/tia_phase_pkg.sv
// rtl/tia_phase_pkg.sv - shared constants and ratio clamp helper for the TIA phase divider family
package tia_phase_pkg;

    localparam int unsigned MIN_DIV           = 2;
    localparam int          DEFAULT_DIV_WIDTH = 4;
    localparam int          DEFAULT_DIV_RATIO = 3;

    // Ratios below MIN_DIV would make phi1/phi2/phi_theta collide, so they are raised to MIN_DIV
    function automatic int unsigned clamp_div(input int unsigned ratio);
        return (ratio < MIN_DIV) ? MIN_DIV : ratio;
    endfunction

endpackage

// File: rtl/tia_phase_decode.sv
// rtl/tia_phase_decode.sv - combinational phase-enable decode of count and ratio
module tia_phase_decode
    import tia_phase_pkg::*;
#(
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
    input  logic [DIV_WIDTH-1:0] cnt,
    input  logic [DIV_WIDTH-1:0] n,
    output logic                 phi_theta,
    output logic                 phi1,
    output logic                 phi2
);

    logic [DIV_WIDTH-1:0] w_last;
    logic [DIV_WIDTH-1:0] w_mid;

    assign w_last = n - DIV_WIDTH'(1);
    assign w_mid  = n >> 1;

    // Terminal count, start-of-period and mid-period enables; N >= 2 keeps phi1 and phi2 disjoint
    always_comb begin
        phi_theta = (cnt == w_last);
        phi1      = (cnt == '0);
        phi2      = (cnt == w_mid);
    end

endmodule

// File: rtl/tia_phase_divider.sv
// rtl/tia_phase_divider.sv - programmable phase divider; optional deferred resync under TIA_PHASE_DIVIDER_RSYN_HOLD_EN
module tia_phase_divider
    import tia_phase_pkg::*;
#(
    parameter int DIV_WIDTH   = DEFAULT_DIV_WIDTH,
    parameter int DEFAULT_DIV = DEFAULT_DIV_RATIO
) (
    input  logic                 clk,
    input  logic                 resphi0,
    input  logic [DIV_WIDTH-1:0] div_ratio,
    input  logic                 div_load,
    input  logic                 rsyn,
    output logic                 phi_theta,
    output logic                 phi1,
    output logic                 phi2,
    output logic                 rsyn_gated,
    output logic [DIV_WIDTH-1:0] cnt,
    output logic [DIV_WIDTH-1:0] div_active,
    output logic                 rsyn_pending
);

    localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DEFAULT_DIV);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div_active;
    logic [DIV_WIDTH-1:0] r_pend_div;
    logic                 r_pend_valid;

    logic                 w_theta;
    logic                 w_rsyn_accept;
    logic                 w_restart;
    logic [DIV_WIDTH-1:0] w_clamped;
    logic [DIV_WIDTH-1:0] w_next_div;

    tia_phase_decode #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_decode (
        .cnt       (r_cnt),
        .n         (r_div_active),
        .phi_theta (w_theta),
        .phi1      (phi1),
        .phi2      (phi2)
    );

    assign w_clamped = DIV_WIDTH'(clamp_div(32'(div_ratio)));

`ifdef TIA_PHASE_DIVIDER_RSYN_HOLD_EN
    logic r_rsyn_hold;

    // A resync landing on terminal count is remembered and replayed one cycle later
    always_ff @(posedge clk) begin
        if (resphi0) begin
            r_rsyn_hold <= 1'b0;
        end else begin
            r_rsyn_hold <= rsyn & w_theta;
        end
    end

    assign w_rsyn_accept = (rsyn & ~w_theta) | r_rsyn_hold;
    assign rsyn_pending  = r_rsyn_hold;
`else
    assign w_rsyn_accept = rsyn & ~w_theta;
    assign rsyn_pending  = 1'b0;
`endif

    // Restart points are the natural wrap and any accepted resync
    assign w_restart = w_theta | w_rsyn_accept;

    // A load coinciding with a restart wins over an older pending ratio
    always_comb begin
        w_next_div = r_div_active;
        if (div_load) begin
            w_next_div = w_clamped;
        end else if (r_pend_valid) begin
            w_next_div = r_pend_div;
        end
    end

    // Count, ratio and pending-slot state; the ratio only changes as the count returns to 0
    always_ff @(posedge clk) begin
        if (resphi0) begin
            r_cnt        <= '0;
            r_div_active <= RESET_DIV;
            r_pend_div   <= RESET_DIV;
            r_pend_valid <= 1'b0;
        end else if (w_restart) begin
            r_cnt        <= '0;
            r_div_active <= w_next_div;
            r_pend_valid <= 1'b0;
        end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
            if (div_load) begin
                r_pend_div   <= w_clamped;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign phi_theta  = w_theta;
    assign rsyn_gated = rsyn & ~w_theta;
    assign cnt        = r_cnt;
    assign div_active = r_div_active;

endmodule

// File: tb/tb_tia_phase_divider.sv
// tb/tb_tia_phase_divider.sv - directed-vector scoreboard bench for tia_phase_divider
module tb_tia_phase_divider;

    logic       clk = 1'b0;
    logic       resphi0;
    logic [3:0] div_ratio;
    logic       div_load;
    logic       rsyn;
    logic       phi_theta;
    logic       phi1;
    logic       phi2;
    logic       rsyn_gated;
    logic [3:0] cnt;
    logic [3:0] div_active;
    logic       rsyn_pending;

    typedef struct {
        int idx;
        int cnt;
        int n;
        bit theta;
        bit phi1;
        bit phi2;
        bit gated;
        bit pend;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_idx  = 0;
    bit   drv_done = 1'b0;

    always #5 clk = ~clk;

    tia_phase_divider #(
        .DIV_WIDTH   (4),
        .DEFAULT_DIV (3)
    ) dut (
        .clk          (clk),
        .resphi0      (resphi0),
        .div_ratio    (div_ratio),
        .div_load     (div_load),
        .rsyn         (rsyn),
        .phi_theta    (phi_theta),
        .phi1         (phi1),
        .phi2         (phi2),
        .rsyn_gated   (rsyn_gated),
        .cnt          (cnt),
        .div_active   (div_active),
        .rsyn_pending (rsyn_pending)
    );

    // One cycle of stimulus plus the hand-computed state the DUT shows during that cycle
    task automatic vec(input bit rst, input bit ld, input int ratio, input bit rs,
                       input int ecnt, input int en, input bit egated, input bit epend);
        exp_t e;
        @(negedge clk);
        #1;
        resphi0   = rst;
        div_load  = ld;
        div_ratio = 4'(ratio);
        rsyn      = rs;
        e.idx   = vec_idx;
        e.cnt   = ecnt;
        e.n     = en;
        e.theta = (ecnt == en - 1);
        e.phi1  = (ecnt == 0);
        e.phi2  = (ecnt == (en >> 1));
        e.gated = egated;
        e.pend  = epend;
        q.push_back(e);
        vec_idx++;
    endtask

    task automatic idle(input int k, input int c0, input int n);
        for (int i = 0; i < k; i++) begin
            vec(0, 0, 0, 0, (c0 + i) % n, n, 0, 0);
        end
    endtask

    task automatic driver();
        resphi0   = 1'b1;
        div_ratio = 4'd0;
        div_load  = 1'b0;
        rsyn      = 1'b0;
        repeat (2) @(posedge clk);
        // default N = 3, four periods
        idle(12, 0, 3);
        // load 5 at cnt 1: current period finishes at N = 3
        vec(0, 0, 0, 0, 0, 3, 0, 0);
        vec(0, 1, 5, 0, 1, 3, 0, 0);
        vec(0, 0, 0, 0, 2, 3, 0, 0);
        idle(10, 0, 5);
        // loads of 0 then 1 clamp to 2; a load on the TC cycle applies at that wrap
        vec(0, 1, 0, 0, 0, 5, 0, 0);
        vec(0, 1, 1, 0, 1, 5, 0, 0);
        idle(3, 2, 5);
        idle(3, 0, 2);
        vec(0, 1, 4, 0, 1, 2, 0, 0);
        // N = 4: accepted resync at cnt 1, dropped resync at cnt 3
        vec(0, 0, 0, 0, 0, 4, 0, 0);
        vec(0, 0, 0, 1, 1, 4, 1, 0);
        idle(3, 0, 4);
        vec(0, 0, 0, 1, 3, 4, 0, 0);
`ifdef TIA_PHASE_DIVIDER_RSYN_HOLD_EN
        vec(0, 0, 0, 0, 0, 4, 0, 1);
`endif
        idle(4, 0, 4);
        // rsyn held high keeps the count at 0
        vec(0, 0, 0, 1, 0, 4, 1, 0);
        vec(0, 0, 0, 1, 0, 4, 1, 0);
        vec(0, 0, 0, 1, 0, 4, 1, 0);
        idle(2, 0, 4);
        // N = 9, pending 6, reset at cnt 7 with load and rsyn also asserted
        vec(0, 1, 9, 0, 2, 4, 0, 0);
        vec(0, 0, 0, 0, 3, 4, 0, 0);
        idle(5, 0, 9);
        vec(0, 1, 6, 0, 5, 9, 0, 0);
        vec(0, 0, 0, 0, 6, 9, 0, 0);
        vec(1, 1, 6, 1, 7, 9, 1, 0);
        idle(4, 0, 3);
        // maximum ratio 15
        vec(0, 1, 15, 0, 1, 3, 0, 0);
        vec(0, 0, 0, 0, 2, 3, 0, 0);
        idle(16, 0, 15);
        vec(0, 1, 3, 0, 1, 15, 0, 0);
        idle(13, 2, 15);
        idle(2, 0, 3);
        // rsyn on terminal count at N = 3
        vec(0, 0, 0, 1, 2, 3, 0, 0);
`ifdef TIA_PHASE_DIVIDER_RSYN_HOLD_EN
        vec(0, 0, 0, 0, 0, 3, 0, 1);
`endif
        idle(4, 0, 3);
        drv_done = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        while (!(drv_done && q.size() == 0)) begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (int'(cnt) != e.cnt || int'(div_active) != e.n || phi_theta != e.theta ||
                    phi1 != e.phi1 || phi2 != e.phi2 || rsyn_gated != e.gated ||
                    rsyn_pending != e.pend) begin
                    n_fail++;
                    $display("FAIL vec%0d: got cnt=%0d n=%0d th=%0b p1=%0b p2=%0b g=%0b pend=%0b, expected cnt=%0d n=%0d th=%0b p1=%0b p2=%0b g=%0b pend=%0b",
                             e.idx, cnt, div_active, phi_theta, phi1, phi2, rsyn_gated, rsyn_pending,
                             e.cnt, e.n, e.theta, e.phi1, e.phi2, e.gated, e.pend);
                end
            end
        end
    endtask

    initial begin
        fork
            driver();
            monitor();
        join
        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL check_count: got %0d, expected at least 12", n_checks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/tia_phase_divider.md
Name: tia_phase_divider

Overview:
- Parametrised, fully synchronous successor to the fixed divide-by-three phase generator.
- Divides clk by a runtime-programmable ratio N and produces three clk-wide enables: terminal-count pulse phi_theta and non-overlapping phase enables phi1/phi2.
- Gates the resync request against phi_theta.
- Sits between the master colour clock and downstream TIA/CPU phase logic; consumers use the enables, never derived clocks.

Parameters:
- DIV_WIDTH, 4: width of ratio and count registers.
- DEFAULT_DIV, 3: ratio loaded on reset; must satisfy 2 <= DEFAULT_DIV <= 2**DIV_WIDTH-1.

Ports:
- clk  in  1  master clock, all state on rising edge.
- resphi0  in  1  reset, synchronous, active-high.
- div_ratio  in  DIV_WIDTH  requested ratio; values 0 and 1 are clamped to 2.
- div_load  in  1  capture div_ratio this cycle into the pending slot.
- rsyn  in  1  resync request; restart the count at 0.
- phi_theta  out  1  high for one clk while cnt == N-1.
- phi1  out  1  high while cnt == 0.
- phi2  out  1  high while cnt == N>>1.
- rsyn_gated  out  1  rsyn & ~phi_theta (combinational).
- cnt  out  DIV_WIDTH  current phase count.
- div_active  out  DIV_WIDTH  ratio N in effect.
- rsyn_pending  out  1  deferred-resync flag; constant 0 unless the optional feature is compiled in.

Behaviour:
Registers:
- cnt, div_active (N), pend_div, pend_valid, rsyn_hold (optional feature only).
- All outputs are combinational decodes of registers plus rsyn, so they change in the cycle after the causing edge.

Reset:
- When resphi0 = 1 at an edge: cnt = 0, N = DEFAULT_DIV, pend_valid = 0, rsyn_hold = 0.
- First cycle after reset: phi1 = 1, phi2 = 0, phi_theta = 0, rsyn_pending = 0.
- resphi0 overrides all other inputs in the same cycle, including a mid-period load or rsyn.

Count:
- Terminal count (TC) = (cnt == N-1).
- cnt advances 0, 1, ..., N-1, 0.
- phi_theta = TC, so its period is exactly N clk.

Ratio load:
- div_load = 1 writes clamp(div_ratio) into pend_div and sets pend_valid.
- A later load in the same period overwrites it (last load wins).
- The pending value is applied at the next restart point, where N = pend_div and pend_valid clears. Restart points are wrap-at-TC or an accepted rsyn.
- A load in the same cycle as a restart point takes effect at that restart.
- N never changes mid-period, so phi_theta never produces a short or long period from a load alone.

Resync:
- rsyn with phi_theta = 0: accepted; next cnt = 0, with pending ratio applied as above.
- rsyn with phi_theta = 1: dropped, and rsyn_gated = 0. The wrap occurs anyway, so phase is unchanged.
- rsyn held high continuously: cnt stays at 0 and phi1 stays high. This is legal.

Phase enables:
- phi2 index is N>>1. For N >= 2 it is never 0, so phi1 and phi2 never overlap.
- N = 2: phi1 and phi2 alternate and phi_theta == phi2.
- N = 3: phi1@0, phi2@1, phi_theta@2.
- Maximum N = 2**DIV_WIDTH-1 (15 by default).
- cnt never exceeds N-1, because N changes only when cnt returns to 0.

Optional Feature:
- Macro: TIA_PHASE_DIVIDER_RSYN_HOLD_EN.
- Defined: an rsyn arriving while phi_theta = 1 sets rsyn_hold instead of being dropped.
  - rsyn_pending = rsyn_hold.
  - On the next cycle the held request is applied as an accepted resync: cnt stays at 0, and phi1 is high for 2 cycles.
  - rsyn_hold then clears.
  - rsyn_gated is unchanged (still masked).
- Undefined: rsyn_hold is absent and rsyn_pending is tied to 0.

Decomposition:
- Package tia_phase_pkg holds:
  - MIN_DIV = 2;
  - default DIV_WIDTH and DEFAULT_DIV constants;
  - function clamp_div(ratio) returning max(ratio, MIN_DIV).
- One natural combinational sub-module, tia_phase_decode: takes cnt and N and produces phi_theta, phi1 and phi2. It is reused by later multi-phase variants.
- The counter, load and resync logic stays in the top module.

Test Plan:
- Reset, default N = 3, run 12 clk -> phi1 high at cycles 0, 3, 6, 9; phi2 at 1, 4, 7, 10; phi_theta at 2, 5, 8, 11; never two high at once.
- div_ratio = 5 with div_load at cnt = 1 -> current period finishes at N = 3, then div_active = 5; phi_theta every 5 clk; phi2 at cnt = 2.
- div_ratio = 0, then 1, each loaded -> div_active = 2; phi1 and phi2 alternate every clk.
- rsyn at cnt = 1 (N = 4) -> next cnt = 0, no phi_theta emitted for that period; rsyn at cnt = 3 -> rsyn_gated = 0, normal wrap, period 4.
- resphi0 asserted at cnt = 7 of N = 9 with a pending load of 6 -> next cycle cnt = 0, div_active = 3, pend_valid = 0; the pending value is never applied.
- With TIA_PHASE_DIVIDER_RSYN_HOLD_EN: rsyn during phi_theta (N = 3) -> rsyn_pending = 1 for one cycle, cnt = 0 for 2 cycles, phi_theta period 4 once, then 3.
